mem_stage: RTL

- Memory-access pipeline stage between EX and WB of the 5-stage MIPS core.
- Latches the EX result and performs load/store through a req/ack data-memory port; stalls the pipeline while the port is busy.
- Produces the mem_wreg/mem_waddr/mem_wdata forwarding triple consumed by the register file's bypass network.
- Owns the MEM/WB pipeline register that drives the register file write port (we/waddr/wdata).

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_align.sv | 81 ++++++++
 rtl/mem_stage.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the MEM pipeline stage and its alignment helper:
//   - MEM_OP_* operation codes carried from decode through EX into MEM
//   - is_load / is_store range helpers over those codes
//   - natural-alignment test used when MEM_MISALIGN_EXC_EN is defined
//   - MEM stage FSM state encoding
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  // Memory operation codes. Loads occupy the contiguous range LB..LW and
  // stores SB..SW, which is what the range helpers below rely on.
  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  // MEM stage FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  // True when a halfword/word access is not naturally aligned.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    logic half_op;
    logic word_op;
    half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
    word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
    return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
//   Purely combinational little-endian lane logic for a 32-bit data bus.
//   Loads:  selects the addressed byte/halfword from the bus word and sign-
//           or zero-extends it according to the op code.
//   Stores: produces byte enables and replicates the store datum across all
//           lanes so the slave can pick whichever lanes are enabled.
//
//   Ports
//     op_i       MEM_OP_* code
//     addr_lo_i  effective address bits [1:0]
//     rdata_i    raw word returned by the data bus
//     sdata_i    store operand (rt)
//     ld_data_o  extended load value
//     be_o       byte enables (all lanes for loads, 0 for non-memory ops)
//     st_data_o  lane-replicated store data
// ---------------------------------------------------------------------------
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] ld_data_o,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: lane select then extend.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    // Halfword lane depends on addr[1] only; addr[0] is ignored here.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ld_data_o = rdata_i;
    case (op_i)
      MEM_OP_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: ld_data_o = {24'b0, byte_sel};
      MEM_OP_LH:  ld_data_o = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: ld_data_o = {16'b0, half_sel};
      default:    ld_data_o = rdata_i;
    endcase
  end

  // Store path: enables and replicated data. Loads read the whole word and
  // extract locally, so they enable every lane.
  always_comb begin
    be_o      = 4'b0000;
    st_data_o = sdata_i;
    case (op_i)
      MEM_OP_SB: begin
        be_o      = 4'b0001 << addr_lo_i;
        st_data_o = {4{sdata_i[7:0]}};
      end
      MEM_OP_SH: begin
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{sdata_i[15:0]}};
      end
      MEM_OP_SW: begin
        be_o      = 4'b1111;
        st_data_o = sdata_i;
      end
      default: begin
        be_o      = is_load(op_i) ? 4'b1111 : 4'b0000;
        st_data_o = sdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   MEM stage of the 5-stage MIPS core, sitting between EX and WB.
//   - Latches the EX result into the stage register whenever the stage is
//     not stalling.
//   - Runs loads/stores over a req/ack data-memory port, holding stall_req
//     while the access is outstanding.
//   - Drives the mem_wreg/mem_waddr/mem_wdata forwarding triple.
//   - Owns the MEM/WB register that drives the register-file write port.
//
//   Optional feature: define MEM_MISALIGN_EXC_EN to raise adel/ades with
//   badvaddr for misaligned halfword/word accesses instead of issuing them.
//   Without it, adel/ades/badvaddr are 0 and dmem_addr is forced aligned.
//
//   Ports
//     clk, rst              clock / synchronous active-high reset
//     flush                 kill the instruction held in this stage
//     ex_*                  instruction arriving from EX
//     stall_req             freeze IF/ID/EX and this stage's input latch
//     mem_load_pending      load in flight (ID interlock)
//     mem_wreg/waddr/wdata  forwarding triple
//     dmem_*                data-memory port
//     wb_we/waddr/wdata     register-file write port
//     adel/ades/badvaddr    address-error exception report
//     dbg_state             current FSM state (mem_stage_pkg::state_e)
//
//   Data-memory handshake: dmem_req is high for every cycle of an access and
//   dmem_addr/we/be/wdata are stable while it is high. The transfer completes
//   in the cycle dmem_ack is high; load data on dmem_rdata is valid only in
//   that cycle. req is never withdrawn before ack except by rst.
// ---------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic          ex_wreg,
  input  logic [4:0]    ex_waddr,
  input  logic [DW-1:0] ex_result,
  input  logic [3:0]    ex_mem_op,
  input  logic [DW-1:0] ex_store_data,
  output logic          stall_req,
  output logic          mem_load_pending,
  output logic          mem_wreg,
  output logic [4:0]    mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [3:0]    dmem_be,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_we,
  output logic [4:0]    wb_waddr,
  output logic [DW-1:0] wb_wdata,
  output logic          adel,
  output logic          ades,
  output logic [DW-1:0] badvaddr,
  output logic [1:0]    dbg_state
);

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_e        state_q, state_d;

  logic          valid_q,  valid_d;
  logic          wreg_q,   wreg_d;
  logic [4:0]    waddr_q,  waddr_d;
  logic [DW-1:0] result_q, result_d;
  logic [3:0]    op_q,     op_d;
  logic [DW-1:0] sdata_q,  sdata_d;
  // Flush seen while the bus access was outstanding; applied at ack.
  logic          kill_q,   kill_d;
  // Latched address-error flags for the instruction in the stage.
  logic          exc_ld_q, exc_ld_d;
  logic          exc_st_q, exc_st_d;

  logic          wb_we_q,    wb_we_d;
  logic [4:0]    wb_waddr_q, wb_waddr_d;
  logic [DW-1:0] wb_wdata_q, wb_wdata_d;

  logic          take;      // EX instruction is accepted as live
  logic          ex_is_mem;
  logic          mis_ld;
  logic          mis_st;

  logic [31:0]   al_ld;
  logic [3:0]    al_be;
  logic [31:0]   al_st;

  // -------------------------------------------------------------------------
  // Alignment helper
  // -------------------------------------------------------------------------
  mem_align u_align (
    .op_i      (op_q),
    .addr_lo_i (result_q[1:0]),
    .rdata_i   (dmem_rdata),
    .sdata_i   (sdata_q),
    .ld_data_o (al_ld),
    .be_o      (al_be),
    .st_data_o (al_st)
  );

  // -------------------------------------------------------------------------
  // Incoming instruction classification
  // -------------------------------------------------------------------------
  assign take      = ex_valid & ~flush;
  assign ex_is_mem = is_load(ex_mem_op) | is_store(ex_mem_op);

`ifdef MEM_MISALIGN_EXC_EN
  assign mis_ld = is_load(ex_mem_op)  & misaligned(ex_mem_op, ex_result[1:0]);
  assign mis_st = is_store(ex_mem_op) & misaligned(ex_mem_op, ex_result[1:0]);
`else
  assign mis_ld = 1'b0;
  assign mis_st = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Misaligned ops skip the bus and report in a single DONE cycle.
        if (take && (mis_ld || mis_st)) begin
          state_d = ST_DONE;
        end else if (take && ex_is_mem) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    stall_req        = (state_q == ST_ACCESS);
    dmem_req         = stall_req;
    dmem_we          = stall_req & is_store(op_q);
    dmem_be          = stall_req ? al_be : 4'b0000;
    // Low address bits never reach the bus; lane selection uses them.
    dmem_addr        = stall_req ? {result_q[AW-1:2], 2'b00} : '0;
    dmem_wdata       = dmem_we ? al_st : '0;
    mem_load_pending = stall_req & valid_q & is_load(op_q);
    // flush drops the forward combinationally in IDLE/DONE.
    mem_wreg         = ~stall_req & valid_q & wreg_q & ~flush & ~exc_ld_q & ~exc_st_q;
    mem_waddr        = waddr_q;
    mem_wdata        = result_q;
`ifdef MEM_MISALIGN_EXC_EN
    adel             = (state_q == ST_DONE) & exc_ld_q;
    ades             = (state_q == ST_DONE) & exc_st_q;
    badvaddr         = (adel | ades) ? result_q : '0;
`else
    adel             = 1'b0;
    ades             = 1'b0;
    badvaddr         = '0;
`endif
    dbg_state        = state_q;
  end

  // -------------------------------------------------------------------------
  // Stage register next-state
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    wreg_d   = wreg_q;
    waddr_d  = waddr_q;
    result_d = result_q;
    op_d     = op_q;
    sdata_d  = sdata_q;
    kill_d   = kill_q;
    exc_ld_d = exc_ld_q;
    exc_st_d = exc_st_q;

    if (!stall_req) begin
      valid_d  = take;
      wreg_d   = ex_wreg;
      waddr_d  = ex_waddr;
      result_d = ex_result;
      op_d     = ex_mem_op;
      sdata_d  = ex_store_data;
      kill_d   = 1'b0;
      exc_ld_d = take & mis_ld;
      exc_st_d = take & mis_st;
    end else begin
      // The bus access always completes; a flush during it only marks the
      // instruction dead so it neither forwards nor writes back.
      if (flush) begin
        kill_d = 1'b1;
      end
      if (dmem_ack) begin
        if (is_load(op_q)) begin
          result_d = al_ld;
        end
        valid_d = valid_q & ~kill_q & ~flush;
        kill_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      waddr_q  <= 5'd0;
      result_q <= '0;
      op_q     <= MEM_OP_NONE;
      sdata_q  <= '0;
      kill_q   <= 1'b0;
      exc_ld_q <= 1'b0;
      exc_st_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wreg_q   <= wreg_d;
      waddr_q  <= waddr_d;
      result_q <= result_d;
      op_q     <= op_d;
      sdata_q  <= sdata_d;
      kill_q   <= kill_d;
      exc_ld_q <= exc_ld_d;
      exc_st_q <= exc_st_d;
    end
  end

  // -------------------------------------------------------------------------
  // MEM/WB register. r0 is hardwired zero, so it is never written.
  // -------------------------------------------------------------------------
  always_comb begin
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    if (!stall_req) begin
      wb_we_d    = mem_wreg & (mem_waddr != 5'd0);
      wb_waddr_d = mem_waddr;
      wb_wdata_d = mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q    <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_wdata_q <= '0;
    end else begin
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign wb_we    = wb_we_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_wdata = wb_wdata_q;

endmodule
